// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and IF/DOF pipeline register with stall and redirect squashing
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          FLUSH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [31:0] ir_in,
    input  logic [15:0] pc1_in,
    output logic [15:0] pc_out,
    output logic [31:0] ir_out,
    output logic [15:0] pc1_out,
    output logic        valid_out,
    output logic [15:0] issue_count
);
    typedef enum logic {RUN, FLUSH} state_t;
    localparam logic [2:0] cnt_init = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
    state_t     state;
    logic [2:0] cnt;
    // reset > redirect > stall > advance; FLUSH keeps PC on the target while emitting bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out      <= RESET_PC;
            ir_out      <= 32'h0;
            pc1_out     <= 16'h0;
            valid_out   <= 1'b0;
            issue_count <= 16'h0;
            state       <= RUN;
            cnt         <= 3'd0;
        end else if (state == RUN) begin
            if (redirect) begin
                pc_out    <= redirect_pc;
                ir_out    <= 32'h0;
                valid_out <= 1'b0;
                if (FLUSH_CYCLES > 0) begin
                    state <= FLUSH;
                    cnt   <= cnt_init;
                end
            end else if (!stall) begin
                pc_out      <= pc1_in;
                ir_out      <= ir_in;
                pc1_out     <= pc1_in;
                valid_out   <= 1'b1;
                issue_count <= issue_count + 16'd1;
            end
        end else begin
            ir_out    <= 32'h0;
            valid_out <= 1'b0;
            if (redirect) begin
                pc_out <= redirect_pc;
                cnt    <= cnt_init;
            end else if (!stall) begin
                if (cnt == 3'd0) state <= RUN;
                else cnt <= cnt - 3'd1;
            end
        end
    end
endmodule
